q_update_engine: RTL and testbench
==================================

Name: q_update_engine

Overview:
Parametrised Q-learning update engine holding a NUM_STATES x NUM_ACTIONS fixed-point Q-table in per-action banks.
Each accepted request performs either a full update, Q[s][a] += alpha*(r + gamma*max_a' Q[s'][a'] - Q[s][a]), or a greedy query (argmax/max over one row).
A multi-cycle FSM sequences the work, with valid/ready handshakes on both sides and a table-clear sweep.
Sits between the agent/environment controller and the policy logic.

Parameters:
DATA_W, 16, Q/reward width, signed two's complement with FRAC_W fractional bits
FRAC_W, 8, fractional bits of Q, reward, alpha and gamma
STATE_W, 4, state index width; NUM_STATES = 2**STATE_W
NUM_ACTIONS, 16, action banks (>=2); ACTION_W = clog2(NUM_ACTIONS)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  start a table-clear sweep; sampled only in IDLE
busy  out  1  high in every state except IDLE
in_valid  in  1  request valid
in_ready  out  1  high only in IDLE with clr low
in_op  in  1  0 = update, 1 = query
in_state  in  STATE_W  s
in_action  in  ACTION_W  a (update only)
in_next_state  in  STATE_W  s' (update only)
in_reward  in  DATA_W  r, signed
in_alpha  in  DATA_W  learning rate, unsigned, FRAC_W fraction
in_gamma  in  DATA_W  discount, unsigned, FRAC_W fraction
out_valid  out  1  result valid
out_ready  in  1  result accepted
out_q  out  DATA_W  update: new Q[s][a]; query: max over row s
out_action  out  ACTION_W  update: greedy action of s'; query: greedy action of s

Behaviour:
- Reset: FSM to IDLE. out_valid=0, out_q=0, out_action=0, busy=0, in_ready=1. Q-table contents are not reset; clr is required after power-up.
- Accept: in_valid & in_ready on a clock edge latches all in_* fields. Fields are ignored at all other times.
- States: IDLE, READ, MAX, TD, UPD, WB, RESP, CLEAR.
- Update path: IDLE -> READ -> MAX -> TD -> UPD -> WB -> RESP. out_valid rises 6 cycles after the accept edge.
- Query path: IDLE -> READ -> MAX -> RESP. out_valid rises 3 cycles after the accept edge.
- READ: port A address = s; port B address = s' (update) or s (query), all banks in parallel. Reads are synchronous with 1-cycle latency.
- MAX: registers the max value and argmax over the port-B row, plus q_sa = port-A word of bank a. Ties resolve to the lowest action index.
- TD: td = r + ((gamma*maxQ) >>> FRAC_W), minus q_sa. Computed at DATA_W+2 bits, no saturation at this stage.
- UPD: q_new = sat(q_sa + ((alpha*td) >>> FRAC_W)).
  - Products are full width; the shift is arithmetic, truncating toward -inf.
  - sat clamps to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
- WB: single-cycle write of q_new into bank a at address s. Exactly one write per update.
- RESP: out_valid=1; out_q and out_action are held stable until out_valid & out_ready, then the FSM returns to IDLE.
  - With out_ready tied high, back-to-back throughput is 7 cycles per update and 4 per query.
- CLEAR:
  - Entered from IDLE when clr=1; clr wins over a simultaneous in_valid, which is not accepted.
  - Writes 0 to address k of every bank on cycle k, for k = 0..NUM_STATES-1, then returns to IDLE after NUM_STATES cycles.
  - clr is ignored outside IDLE.
- Read-after-write: no hazard, since a request is only accepted after the previous write has committed.
- s == s': legal; reads see the pre-update value.
- Reset mid-operation: returns to IDLE immediately. A write already committed stays; an in-flight update does not write. A clear in progress leaves the table partially cleared.

Decomposition:
- Shared package q_learn_pkg:
  - default DATA_W/FRAC_W
  - op encoding (OP_UPDATE=0, OP_QUERY=1)
  - FSM state enum
  - saturating-resize function
  - argmax tie rule constant
- Sub-module q_bank: 1-write / 2-read synchronous RAM, depth NUM_STATES, width DATA_W. Instantiated NUM_ACTIONS times via generate.
- Max/argmax: a combinational reduction in the top level.

Test Plan:
- Clear, then update s=3, a=2, s'=4, r=0x0100, alpha=0x0080, gamma=0x00E6 -> out_valid 6 cycles after accept; out_q=0x0080, out_action=0.
- Query s=3 after the above -> out_q=0x0080, out_action=2, out_valid 3 cycles after accept; an all-equal row returns action 0.
- Update s=2, a=5, s'=3, r=0, alpha=0x0100, gamma=0x0080 -> out_q=0x0040. Then update s=1, a=0, s'=1, r=0xFF00 (-1.0), alpha=0x0100, gamma=0 -> out_q=0xFF00.
- Saturation: clear, then update s=a=s'=0, r=0x7FFF, alpha=gamma=0x0100 -> 0x7FFF. Repeating the same request -> out_q=0x7FFF (clamped, no wrap).
- Backpressure: out_ready=0 for 5 cycles -> out_valid, out_q and out_action stable, in_ready=0, no extra write. A second request is accepted only after the handshake.
- Assert rst during TD of an update -> all outputs at reset values at once, target entry unchanged. Assert clr together with in_valid in IDLE -> CLEAR for NUM_STATES cycles, request not accepted, all queries then return 0.

Source files
------------

// File: rtl/q_learn_pkg.sv
// Shared definitions for the Q-learning update engine.
// Holds default widths, the request op encoding, the FSM state enum,
// the argmax tie rule and a saturating resize helper.
package q_learn_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int FRAC_W_DEF = 8;

   localparam logic OP_UPDATE = 1'b0;
   localparam logic OP_QUERY  = 1'b1;

   // When set, equal row entries keep the lower action index.
   localparam bit ARGMAX_LOWEST_IDX = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_MAX,
      ST_TD,
      ST_UPD,
      ST_WB,
      ST_RESP,
      ST_CLEAR
   } state_e;

   // Clamp a wide signed value into the range of a w-bit signed word.
   function automatic logic signed [63:0] sat_resize(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] res;
      hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (w - 1));
      res = v;
      if (v > hi) begin
         res = hi;
      end else if (v < lo) begin
         res = lo;
      end
      return res;
   endfunction

endpackage

// File: rtl/q_update_engine_bank.sv
// One action bank of the Q-table: 1 write port, 2 synchronous read ports.
// Latency: read data appears one clock after the address; write commits on the edge.
// Backpressure: none, the bank accepts a write or read every cycle.
// Ports: clk; we/waddr/wdata write port; raddr_a/rdata_a and raddr_b/rdata_b read ports.
module q_bank #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];
   logic [DATA_W-1:0] rdata_a_q;
   logic [DATA_W-1:0] rdata_b_q;

   // Table contents are deliberately not reset; a clear sweep initialises them.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_a_q <= mem[raddr_a];
      rdata_b_q <= mem[raddr_b];
   end

   assign rdata_a = rdata_a_q;
   assign rdata_b = rdata_b_q;

endmodule

// File: rtl/q_update_engine.sv
// Q-learning update engine: Q[s][a] += alpha*(r + gamma*max Q[s'] - Q[s][a]), or greedy row query.
// Latency: response valid 6 cycles after accept for update, 3 for query; clear sweep takes NUM_STATES cycles.
// Backpressure: one request in flight; in_ready low until the response handshakes, response held while out_ready low.
// Ports: clk/rst; clr + busy; in_* request (valid/ready); out_* response (valid/ready).
module q_update_engine
   import q_learn_pkg::*;
#(
   parameter  int DATA_W      = DATA_W_DEF,
   parameter  int FRAC_W      = FRAC_W_DEF,
   parameter  int STATE_W     = 4,
   parameter  int NUM_ACTIONS = 16,
   localparam int ACTION_W    = $clog2(NUM_ACTIONS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   output logic                busy,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_op,
   input  logic [STATE_W-1:0]  in_state,
   input  logic [ACTION_W-1:0] in_action,
   input  logic [STATE_W-1:0]  in_next_state,
   input  logic [DATA_W-1:0]   in_reward,
   input  logic [DATA_W-1:0]   in_alpha,
   input  logic [DATA_W-1:0]   in_gamma,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   out_q,
   output logic [ACTION_W-1:0] out_action
);

   // Wide enough for alpha (unsigned) times a DATA_W+2 bit td without overflow.
   localparam int PW = 2*DATA_W + 4;

   state_e state_q, state_d;
   logic                      busy_q, busy_d;
   logic                      out_valid_q, out_valid_d;
   logic [DATA_W-1:0]         out_q_q, out_q_d;
   logic [ACTION_W-1:0]       out_action_q, out_action_d;
   logic                      op_q, op_d;
   logic [STATE_W-1:0]        s_q, s_d;
   logic [ACTION_W-1:0]       a_q, a_d;
   logic [STATE_W-1:0]        sn_q, sn_d;
   logic signed [DATA_W-1:0]  r_q, r_d;
   logic [DATA_W-1:0]         alpha_q, alpha_d;
   logic [DATA_W-1:0]         gamma_q, gamma_d;
   logic signed [DATA_W-1:0]  maxq_q, maxq_d;
   logic [ACTION_W-1:0]       amax_q, amax_d;
   logic signed [DATA_W-1:0]  qsa_q, qsa_d;
   logic signed [DATA_W+1:0]  td_q, td_d;
   logic signed [DATA_W-1:0]  qnew_q, qnew_d;
   logic [STATE_W-1:0]        clr_cnt_q, clr_cnt_d;

   logic [DATA_W-1:0]         rd_a [NUM_ACTIONS];
   logic [DATA_W-1:0]         rd_b [NUM_ACTIONS];
   logic [NUM_ACTIONS-1:0]    bank_we;
   logic [STATE_W-1:0]        raddr_b;
   logic [STATE_W-1:0]        waddr;
   logic [DATA_W-1:0]         wdata;

   logic signed [DATA_W-1:0]  row_max;
   logic [ACTION_W-1:0]       row_arg;
   logic signed [PW-1:0]      g_prod, td_full, a_prod, upd_full;
   logic signed [63:0]        upd_sat;

   // ---------------- Q-table banks ----------------
   // Port A always reads row s (for Q[s][a]); port B reads the row whose max is needed.
   assign raddr_b = (op_q == OP_UPDATE) ? sn_q : s_q;
   assign waddr   = (state_q == ST_CLEAR) ? clr_cnt_q : s_q;
   assign wdata   = (state_q == ST_CLEAR) ? '0 : qnew_q;

   always_comb begin
      bank_we = '0;
      for (int i = 0; i < NUM_ACTIONS; i++) begin
         bank_we[i] = (state_q == ST_CLEAR) ||
                      ((state_q == ST_WB) && (a_q == ACTION_W'(i)));
      end
   end

   for (genvar g = 0; g < NUM_ACTIONS; g++) begin : g_bank
      q_bank #(
         .ADDR_W (STATE_W),
         .DATA_W (DATA_W)
      ) u_bank (
         .clk     (clk),
         .we      (bank_we[g]),
         .waddr   (waddr),
         .wdata   (wdata),
         .raddr_a (s_q),
         .rdata_a (rd_a[g]),
         .raddr_b (raddr_b),
         .rdata_b (rd_b[g])
      );
   end

   // ---------------- Row max / argmax ----------------
   always_comb begin
      row_max = $signed(rd_b[0]);
      row_arg = '0;
      for (int i = 1; i < NUM_ACTIONS; i++) begin
         if (ARGMAX_LOWEST_IDX ? ($signed(rd_b[i]) > row_max)
                               : ($signed(rd_b[i]) >= row_max)) begin
            row_max = $signed(rd_b[i]);
            row_arg = ACTION_W'(i);
         end
      end
   end

   // ---------------- TD / update arithmetic ----------------
   // alpha and gamma are unsigned, so a zero sign bit is prepended before the signed multiply.
   always_comb begin
      g_prod   = PW'($signed({1'b0, gamma_q})) * PW'(maxq_q);
      td_full  = PW'(r_q) + (g_prod >>> FRAC_W) - PW'(qsa_q);
      a_prod   = PW'($signed({1'b0, alpha_q})) * PW'(td_q);
      upd_full = PW'(qsa_q) + (a_prod >>> FRAC_W);
      upd_sat  = sat_resize(64'(upd_full), DATA_W);
   end

   // ---------------- FSM next state ----------------
   always_comb begin
      state_d      = state_q;
      out_valid_d  = out_valid_q;
      out_q_d      = out_q_q;
      out_action_d = out_action_q;
      op_d         = op_q;
      s_d          = s_q;
      a_d          = a_q;
      sn_d         = sn_q;
      r_d          = r_q;
      alpha_d      = alpha_q;
      gamma_d      = gamma_q;
      maxq_d       = maxq_q;
      amax_d       = amax_q;
      qsa_d        = qsa_q;
      td_d         = td_q;
      qnew_d       = qnew_q;
      clr_cnt_d    = clr_cnt_q;

      case (state_q)
         ST_IDLE: begin
            // clr has priority; in_ready is low while clr is high so no request is taken.
            if (clr) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
            end else if (in_valid) begin
               state_d = ST_READ;
               op_d    = in_op;
               s_d     = in_state;
               a_d     = in_action;
               sn_d    = in_next_state;
               r_d     = $signed(in_reward);
               alpha_d = in_alpha;
               gamma_d = in_gamma;
            end
         end
         ST_READ: begin
            state_d = ST_MAX;
         end
         ST_MAX: begin
            maxq_d = row_max;
            amax_d = row_arg;
            qsa_d  = $signed(rd_a[a_q]);
            if (op_q == OP_QUERY) begin
               state_d      = ST_RESP;
               out_valid_d  = 1'b1;
               out_q_d      = row_max;
               out_action_d = row_arg;
            end else begin
               state_d = ST_TD;
            end
         end
         ST_TD: begin
            td_d    = (DATA_W+2)'(td_full);
            state_d = ST_UPD;
         end
         ST_UPD: begin
            qnew_d  = DATA_W'(upd_sat);
            state_d = ST_WB;
         end
         ST_WB: begin
            state_d      = ST_RESP;
            out_valid_d  = 1'b1;
            out_q_d      = qnew_q;
            out_action_d = amax_q;
         end
         ST_RESP: begin
            if (out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         end
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // ---------------- Registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         busy_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_q_q      <= '0;
         out_action_q <= '0;
         op_q         <= OP_UPDATE;
         s_q          <= '0;
         a_q          <= '0;
         sn_q         <= '0;
         r_q          <= '0;
         alpha_q      <= '0;
         gamma_q      <= '0;
         maxq_q       <= '0;
         amax_q       <= '0;
         qsa_q        <= '0;
         td_q         <= '0;
         qnew_q       <= '0;
         clr_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         out_valid_q  <= out_valid_d;
         out_q_q      <= out_q_d;
         out_action_q <= out_action_d;
         op_q         <= op_d;
         s_q          <= s_d;
         a_q          <= a_d;
         sn_q         <= sn_d;
         r_q          <= r_d;
         alpha_q      <= alpha_d;
         gamma_q      <= gamma_d;
         maxq_q       <= maxq_d;
         amax_q       <= amax_d;
         qsa_q        <= qsa_d;
         td_q         <= td_d;
         qnew_q       <= qnew_d;
         clr_cnt_q    <= clr_cnt_d;
      end
   end

   assign busy       = busy_q;
   assign in_ready   = (state_q == ST_IDLE) && !clr;
   assign out_valid  = out_valid_q;
   assign out_q      = out_q_q;
   assign out_action = out_action_q;

endmodule

// File: tb/tb_q_update_engine.sv
// Scoreboard bench for q_update_engine: a reference Q-table model predicts every response,
// the driver queues predictions at accept time and an independent monitor checks them.
module tb_q_update_engine;

   localparam int DATA_W      = 16;
   localparam int FRAC_W      = 8;
   localparam int STATE_W     = 4;
   localparam int NUM_ACTIONS = 16;
   localparam int ACTION_W    = 4;
   localparam int NS          = 16;
   localparam int NONE        = -999999;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                clr = 1'b0;
   logic                busy;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic                in_op = 1'b0;
   logic [STATE_W-1:0]  in_state = '0;
   logic [ACTION_W-1:0] in_action = '0;
   logic [STATE_W-1:0]  in_next_state = '0;
   logic [DATA_W-1:0]   in_reward = '0;
   logic [DATA_W-1:0]   in_alpha = '0;
   logic [DATA_W-1:0]   in_gamma = '0;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic [DATA_W-1:0]   out_q;
   logic [ACTION_W-1:0] out_action;

   q_update_engine #(
      .DATA_W      (DATA_W),
      .FRAC_W      (FRAC_W),
      .STATE_W     (STATE_W),
      .NUM_ACTIONS (NUM_ACTIONS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .clr           (clr),
      .busy          (busy),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_op         (in_op),
      .in_state      (in_state),
      .in_action     (in_action),
      .in_next_state (in_next_state),
      .in_reward     (in_reward),
      .in_alpha      (in_alpha),
      .in_gamma      (in_gamma),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_q         (out_q),
      .out_action    (out_action)
   );

   always #5 clk = ~clk;

   typedef struct {
      int q;
      int a;
      int lat;
      int acc;
   } exp_t;

   exp_t sb[$];
   int   qt [NS][NUM_ACTIONS];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   last_acc = 0;
   bit   rand_rdy = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // floor(x / 2**FRAC_W)
   function automatic int fl(input longint x);
      longint d;
      d = longint'(1) << FRAC_W;
      if (x >= 0) return int'(x / d);
      return int'(-((-x + d - 1) / d));
   endfunction

   function automatic int clampq(input longint x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return int'(x);
   endfunction

   task automatic zero_model();
      for (int i = 0; i < NS; i++)
         for (int j = 0; j < NUM_ACTIONS; j++) qt[i][j] = 0;
   endtask

   // Drive one request, wait for acceptance, predict its response from the model.
   task automatic issue(input bit op, input int s, input int a, input int sn, input int r,
                        input int al, input int ga, input int xq, input int xa);
      exp_t e;
      int row, m, mi, qsa, td, qn, budget;
      @(negedge clk);
      in_op = op;
      in_state = STATE_W'(s);
      in_action = ACTION_W'(a);
      in_next_state = STATE_W'(sn);
      in_reward = DATA_W'(r);
      in_alpha = DATA_W'(al);
      in_gamma = DATA_W'(ga);
      in_valid = 1'b1;
      budget = 0;
      while (!in_ready && budget < 300) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", budget);
         in_valid = 1'b0;
         return;
      end
      row = (op == 1'b0) ? sn : s;
      m = qt[row][0];
      mi = 0;
      for (int i = 1; i < NUM_ACTIONS; i++) begin
         if (qt[row][i] > m) begin
            m = qt[row][i];
            mi = i;
         end
      end
      if (op) begin
         e.q = m;
         e.a = mi;
         e.lat = 3;
      end else begin
         qsa = qt[s][a];
         td = r + fl(longint'(ga) * m) - qsa;
         qn = clampq(longint'(qsa) + fl(longint'(al) * td));
         qt[s][a] = qn;
         e.q = qn;
         e.a = mi;
         e.lat = 6;
      end
      if (xq != NONE) e.q = xq;
      if (xa != NONE) e.a = xa;
      e.acc = cyc;
      last_acc = cyc;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || busy) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_timeout: %0d responses outstanding, busy=%0d, required 0/0", sb.size(), busy);
      end
   endtask

   task automatic do_clear(input bit with_req);
      int n;
      @(negedge clk);
      clr = 1'b1;
      if (with_req) begin
         in_op = 1'b1;
         in_state = 4'd9;
         in_valid = 1'b1;
      end
      #1 chk("in_ready_during_clr", in_ready, 0);
      @(negedge clk);
      clr = 1'b0;
      in_valid = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("clear_cycles", n, NS);
      zero_model();
   endtask

   // Monitor: samples between edges, pops the scoreboard on each handshake.
   initial begin
      exp_t e;
      bit held, prev_vld;
      logic [DATA_W-1:0] hq;
      logic [ACTION_W-1:0] ha;
      int rise;
      held = 0;
      prev_vld = 0;
      rise = 0;
      hq = '0;
      ha = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            held = 0;
            prev_vld = 0;
         end else begin
            if (held) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_q", out_q, hq);
               chk("hold_action", out_action, ha);
            end
            if (out_valid && !prev_vld) rise = cyc;
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_output: out_q=%h with nothing outstanding, required no response", out_q);
               end else begin
                  e = sb.pop_front();
                  chk("out_q", longint'($signed(out_q)), e.q);
                  chk("out_action", out_action, e.a);
                  chk("latency", rise - e.acc, e.lat);
               end
            end
            held = out_valid && !out_ready;
            hq = out_q;
            ha = out_action;
            prev_vld = out_valid;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, required self-completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rel, old;
      zero_model();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_q", out_q, 0);
      chk("rst_out_action", out_action, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);

      // Directed functional cases
      do_clear(0);
      issue(0, 3, 2, 4, 256, 128, 230, 128, 0);
      issue(1, 3, 0, 0, 0, 0, 0, 128, 2);
      issue(1, 7, 0, 0, 0, 0, 0, 0, 0);
      issue(0, 2, 5, 3, 0, 256, 128, 64, 2);
      issue(0, 1, 0, 1, -256, 256, 0, -256, 0);
      wait_idle();

      // Saturation
      do_clear(0);
      issue(0, 0, 0, 0, 32767, 256, 256, 32767, 0);
      issue(0, 0, 0, 0, 32767, 256, 256, 32767, 0);
      wait_idle();

      // Backpressure: response held, second request waits for the handshake
      out_ready = 1'b0;
      issue(0, 4, 1, 0, 500, 200, 100, NONE, NONE);
      rel = 0;
      fork
         begin
            repeat (11) @(negedge clk);
            rel = cyc;
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            out_ready = 1'b1;
         end
         issue(1, 4, 0, 0, 0, 0, 0, NONE, NONE);
      join
      chk("accept_after_handshake", longint'(last_acc > rel), 1);
      wait_idle();

      // Reset during TD of an update: no write, outputs back to reset values
      do_clear(0);
      old = qt[5][3];
      issue(0, 5, 3, 5, 1000, 200, 100, NONE, NONE);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_q", out_q, 0);
      chk("mid_rst_out_action", out_action, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      sb.delete();
      qt[5][3] = old;
      @(negedge clk);
      rst = 1'b0;
      issue(1, 5, 0, 0, 0, 0, 0, 0, 0);
      wait_idle();

      // Randomised traffic with random response backpressure
      rand_rdy = 1'b1;
      for (int k = 0; k < 300; k++) begin
         issue(1'($urandom_range(0, 1)), int'($urandom_range(0, NS - 1)),
               int'($urandom_range(0, NUM_ACTIONS - 1)), int'($urandom_range(0, NS - 1)),
               int'($urandom_range(0, 65535)) - 32768,
               int'($urandom_range(0, 256)), int'($urandom_range(0, 256)), NONE, NONE);
      end
      wait_idle();
      rand_rdy = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;

      // clr together with a request: clear wins, every row then reads zero
      do_clear(1);
      for (int s = 0; s < NS; s++) issue(1, s, 0, 0, 0, 0, 0, 0, 0);
      wait_idle();
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
